// File: rtl/router_pkg.sv
// Shared definitions for the parametrised layer router: frame markers,
// BX field location, FSM state type and frame-marker decode helpers.
package router_pkg;

    localparam logic [2:0]  HDR_TAG = 3'b111;
    localparam logic [24:0] HDR_LOW = 25'h1ffffff;
    localparam logic [24:0] TRL_LOW = 25'h0000000;

    // BX number carried in the trailer word
    localparam int BX_HI = 32;
    localparam int BX_LO = 25;

    typedef enum logic [1:0] {
        HEAD  = 2'd0,
        CNTS  = 2'd1,
        STUBS = 2'd2,
        TRAIL = 2'd3
    } state_e;

    // Header: tag bits all ones and low field all ones
    function automatic logic is_header(input logic [2:0] tag, input logic [24:0] low);
        return (tag == HDR_TAG) && (low == HDR_LOW);
    endfunction

    // Trailer: tag bits all ones and low field all zeros
    function automatic logic is_trailer(input logic [2:0] tag, input logic [24:0] low);
        return (tag == HDR_TAG) && (low == TRL_LOW);
    endfunction

endpackage

// File: rtl/stub_layer_select.sv
// Maps a stub index onto the first layer whose cumulative-count window
// [cnt[i-1], cnt[i]) contains it, and flags non-monotonic count vectors.
// Field 0 sits at the MSB end of the packed count vector.
module stub_layer_select #(
    parameter int NLAYER = 6,
    parameter int CNT_W  = 6
) (
    input  logic [CNT_W:0]          k,
    input  logic [NLAYER*CNT_W-1:0] cnt,
    output logic [NLAYER-1:0]       layer_hot,
    output logic                    err_mono
);

    logic [CNT_W:0] prev_s;
    logic [CNT_W:0] hi_s;
    logic           found_s;

    // Walk the layers in order; the first window holding k wins, so
    // overlapping windows from bad counts still give a one-hot result.
    always_comb begin
        layer_hot = {NLAYER{1'b0}};
        err_mono  = 1'b0;
        found_s   = 1'b0;
        prev_s    = {(CNT_W+1){1'b0}};
        hi_s      = {(CNT_W+1){1'b0}};
        for (int i = 0; i < NLAYER; i++) begin
            hi_s = {1'b0, cnt[(NLAYER-i)*CNT_W-1 -: CNT_W]};
            if (hi_s < prev_s) begin
                err_mono = 1'b1;
            end else begin
                err_mono = err_mono;
            end
            if (!found_s && (prev_s <= k) && (k < hi_s)) begin
                layer_hot[i] = 1'b1;
                found_s      = 1'b1;
            end else begin
                layer_hot[i] = 1'b0;
            end
            prev_s = hi_s;
        end
    end

endmodule

// File: rtl/param_layer_router.sv
// Parametrised stub router: reads one event frame per matching BX slot
// (header, cumulative-count word, stubs, trailer) from the input memory
// and writes each stub to its layer memory through a one-hot write enable.
module param_layer_router
    import router_pkg::*;
#(
    parameter int STUB_W = 36,
    parameter int NLAYER = 6,
    parameter int CNT_W  = 6,
    parameter int N_HOLD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_proc,
    input  logic                    start,
    output logic                    done,
    output logic                    read_en,
    input  logic [STUB_W-1:0]       stub_in,
    output logic [NLAYER-1:0]       wr_en,
    output logic [STUB_W-1:0]       stub_out,
    output logic [NLAYER*CNT_W-1:0] stub_cnt_out,
    output logic                    err_frame,
    output logic                    err_count
);

    localparam int CW = NLAYER * CNT_W;
    localparam logic [CNT_W:0] K_ZERO = {(CNT_W+1){1'b0}};
    localparam logic [CNT_W:0] K_ONE  = {{CNT_W{1'b0}}, 1'b1};

    state_e              state_r, state_nx_s;
    logic                active_r;
    logic [2:0]          bx_pipe_r;
    logic [7:0]          bx_read_r, bx_read_nx_s;
    logic [CNT_W:0]      k_r, k_nx_s;
    logic                read_d_r;
    logic                word_v_r;
    logic [STUB_W-1:0]   word_q_r;
    logic [NLAYER-1:0]   wr_en_r, wr_en_nx_s;
    logic [STUB_W-1:0]   stub_out_r, stub_out_nx_s;
    logic [CW-1:0]       cnt_r, cnt_nx_s;
    logic                err_frame_r, err_frame_nx_s;
    logic                err_count_r, err_count_nx_s;
    logic                trail_hit_s;
    logic [N_HOLD:0]     start_sr_r;
    logic                done_r;

    logic [CW-1:0]       word_cnt_s;
    logic [CW-1:0]       sel_cnt_s;
    logic [NLAYER-1:0]   layer_hot_s;
    logic                mono_err_s;
    logic [CNT_W:0]      total_word_s;
    logic [CNT_W:0]      total_lat_s;
    logic                is_hdr_s;
    logic                is_trl_s;

    // Only the slot whose BX matches the last trailer's successor is read
    assign read_en = active_r && (bx_read_r[2:0] == bx_pipe_r);

    assign word_cnt_s   = word_q_r[STUB_W-1 -: CW];
    assign total_word_s = {1'b0, word_cnt_s[CNT_W-1:0]};
    assign total_lat_s  = {1'b0, cnt_r[CNT_W-1:0]};
    assign is_hdr_s     = is_header(word_q_r[STUB_W-1 -: 3], word_q_r[24:0]);
    assign is_trl_s     = is_trailer(word_q_r[STUB_W-1 -: 3], word_q_r[24:0]);

    // While the count word is being parsed, check it directly; afterwards
    // route with the latched copy.
    assign sel_cnt_s = (state_r == CNTS) ? word_cnt_s : cnt_r;

    stub_layer_select #(
        .NLAYER (NLAYER),
        .CNT_W  (CNT_W)
    ) u_sel (
        .k         (k_r),
        .cnt       (sel_cnt_s),
        .layer_hot (layer_hot_s),
        .err_mono  (mono_err_s)
    );

    // Next-state and next-output decode, advancing only on captured words
    always_comb begin
        state_nx_s     = state_r;
        k_nx_s         = k_r;
        wr_en_nx_s     = {NLAYER{1'b0}};
        stub_out_nx_s  = stub_out_r;
        cnt_nx_s       = cnt_r;
        bx_read_nx_s   = bx_read_r;
        err_frame_nx_s = 1'b0;
        err_count_nx_s = 1'b0;
        trail_hit_s    = 1'b0;
        if (word_v_r) begin
            case (state_r)
                HEAD: begin
                    if (is_hdr_s) begin
                        state_nx_s = CNTS;
                    end else begin
                        state_nx_s = HEAD;
                    end
                end
                CNTS: begin
                    cnt_nx_s       = word_cnt_s;
                    err_count_nx_s = mono_err_s;
                    k_nx_s         = K_ZERO;
                    if (total_word_s == K_ZERO) begin
                        state_nx_s = TRAIL;
                    end else begin
                        state_nx_s = STUBS;
                    end
                end
                STUBS: begin
                    if (layer_hot_s != {NLAYER{1'b0}}) begin
                        wr_en_nx_s    = layer_hot_s;
                        stub_out_nx_s = word_q_r;
                    end else begin
                        wr_en_nx_s    = {NLAYER{1'b0}};
                    end
                    if ((k_r + K_ONE) == total_lat_s) begin
                        k_nx_s     = K_ZERO;
                        state_nx_s = TRAIL;
                    end else begin
                        k_nx_s     = k_r + K_ONE;
                        state_nx_s = STUBS;
                    end
                end
                TRAIL: begin
                    trail_hit_s = 1'b1;
                    state_nx_s  = HEAD;
                    if (is_trl_s) begin
                        bx_read_nx_s = word_q_r[BX_HI:BX_LO] + 8'd1;
                    end else begin
                        err_frame_nx_s = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = HEAD;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Input pipeline: delay the read strobe, then capture the memory word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_d_r <= 1'b0;
            word_v_r <= 1'b0;
            word_q_r <= {STUB_W{1'b0}};
        end else if (!en_proc) begin
            read_d_r <= 1'b0;
            word_v_r <= 1'b0;
        end else begin
            read_d_r <= read_en;
            word_v_r <= read_d_r;
            if (read_d_r) begin
                word_q_r <= stub_in;
            end
        end
    end

    // Event-slot bookkeeping: slot counter and frame-in-progress flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bx_pipe_r <= 3'd7;
            active_r  <= 1'b0;
        end else if (!en_proc) begin
            bx_pipe_r <= 3'd7;
            active_r  <= 1'b0;
        end else begin
            if (start) begin
                bx_pipe_r <= bx_pipe_r + 3'd1;
            end
            // a new slot outranks the trailer that closes the old one
            if (start) begin
                active_r <= 1'b1;
            end else if (trail_hit_s) begin
                active_r <= 1'b0;
            end
        end
    end

    // Parser state register and stub index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= HEAD;
            k_r     <= K_ZERO;
        end else if (!en_proc) begin
            state_r <= HEAD;
            k_r     <= K_ZERO;
        end else begin
            state_r <= state_nx_s;
            k_r     <= k_nx_s;
        end
    end

    // Registered outputs; a flush drops pending writes but keeps BX and counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_r     <= {NLAYER{1'b0}};
            stub_out_r  <= {STUB_W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            bx_read_r   <= 8'd0;
            err_frame_r <= 1'b0;
            err_count_r <= 1'b0;
        end else if (!en_proc) begin
            wr_en_r     <= {NLAYER{1'b0}};
            err_frame_r <= 1'b0;
            err_count_r <= 1'b0;
        end else begin
            wr_en_r     <= wr_en_nx_s;
            stub_out_r  <= stub_out_nx_s;
            cnt_r       <= cnt_nx_s;
            bx_read_r   <= bx_read_nx_s;
            err_frame_r <= err_frame_nx_s;
            err_count_r <= err_count_nx_s;
        end
    end

    // done is start delayed through the hold line plus one output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sr_r <= {(N_HOLD+1){1'b0}};
            done_r     <= 1'b0;
        end else begin
            start_sr_r <= (N_HOLD+1)'({start_sr_r, start});
            done_r     <= start_sr_r[N_HOLD];
        end
    end

    assign wr_en        = wr_en_r;
    assign stub_out     = stub_out_r;
    assign stub_cnt_out = cnt_r;
    assign err_frame    = err_frame_r;
    assign err_count    = err_count_r;
    assign done         = done_r;

endmodule
